// File: rtl/rf_pkg.sv
// Shared types and constants for the tree vote accumulator.
// Holds the accumulator state enum and the emission-spacing rules.
package rf_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        WAIT  = 1'b1
    } acc_state_t;

    localparam int CLF_MIN_SPACING = 5;
    localparam int RGS_SPACING     = 3;

    // Cycles the vote buffer needs between results: 2-cycle scan start plus one per label.
    function automatic int emit_spacing(input logic is_clf, input int n_labels);
        if (!is_clf) begin
            return RGS_SPACING;
        end
        return (n_labels + 2 > CLF_MIN_SPACING) ? n_labels + 2 : CLF_MIN_SPACING;
    endfunction

endpackage

// File: rtl/vote_accum_gap_timer.sv
// Emission gap down-counter: loads spacing-1 on emission, counts to zero.
// Latency: zero flag reflects the registered count; no backpressure (free-running).
// Backpressure: none; load has priority over the decrement.
module vote_accum_gap_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] gap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap <= '0;
        end else if (load) begin
            gap <= load_val;
        end else if (gap != '0) begin
            gap <= gap - W'(1);
        end
    end

    assign zero = (gap == '0);

endmodule

// File: rtl/tree_vote_accum.sv
// Collects per-tree leaf results (label votes or regression sum) into a double-buffered result.
// Latency: result pulse 1 cycle after the final leaf when the gap timer is idle, else after it expires.
// Backpressure: o_leaf_rdy drops while a finished sample waits for the gap; VOTE_ACCUM_SATURATE_EN enables saturation.
module tree_vote_accum
    import rf_pkg::*;
#(
    parameter int N_LABELS       = 10,
    parameter int N_LABELS_WIDTH = 4,
    parameter int RES_WIDTH      = 16,
    parameter int N_TREES_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_sample_rst,
    input  logic [N_LABELS_WIDTH-1:0]     i_n_labels,
    input  logic [N_TREES_WIDTH-1:0]      i_n_trees,
    input  logic                          i_is_clf,
    input  logic                          i_leaf_vld,
    output logic                          o_leaf_rdy,
    input  logic [N_LABELS_WIDTH-1:0]     i_leaf_label,
    input  logic [RES_WIDTH-1:0]          i_leaf_value,
    output logic [N_LABELS*RES_WIDTH-1:0] o_clf_accum,
    output logic [RES_WIDTH-1:0]          o_rgs_accum,
    output logic                          o_accum_vld
);

    localparam int GAP_W = N_LABELS_WIDTH + 2;
    localparam int MSB   = RES_WIDTH - 1;

    logic [N_LABELS-1:0][RES_WIDTH-1:0] work_clf, work_clf_nxt, out_clf;
    logic [RES_WIDTH-1:0]               work_rgs, work_rgs_nxt, out_rgs, rgs_sum;
    logic [N_TREES_WIDTH-1:0]           tree_cnt, last_idx;
    logic [GAP_W-1:0]                   gap_load;
    acc_state_t                         state;
    logic                               leaf_rdy, accum_vld;
    logic                               accept, last_leaf, emit, gap_zero;

    assign last_idx  = (i_n_trees == '0) ? '0 : i_n_trees - N_TREES_WIDTH'(1);
    assign accept    = i_leaf_vld & leaf_rdy & ~i_sample_rst;
    assign last_leaf = accept & (tree_cnt == last_idx);
    assign emit      = ~i_sample_rst & gap_zero &
                       (((state == ACCUM) & last_leaf) | (state == WAIT));
    assign gap_load  = GAP_W'(emit_spacing(i_is_clf, int'(i_n_labels)) - 1);

    always_comb begin
        work_clf_nxt = work_clf;
        work_rgs_nxt = work_rgs;
        rgs_sum      = work_rgs + i_leaf_value;
`ifdef VOTE_ACCUM_SATURATE_EN
        // Same-sign operands with a sign flip in the result means signed overflow.
        if ((work_rgs[MSB] == i_leaf_value[MSB]) && (rgs_sum[MSB] != work_rgs[MSB])) begin
            rgs_sum = {work_rgs[MSB], {(RES_WIDTH-1){~work_rgs[MSB]}}};
        end
`endif
        if (accept) begin
            if (i_is_clf) begin
                for (int l = 0; l < N_LABELS; l++) begin
                    if ((i_leaf_label == N_LABELS_WIDTH'(l)) &&
                        (N_LABELS_WIDTH'(l) < i_n_labels)) begin
`ifdef VOTE_ACCUM_SATURATE_EN
                        if (work_clf[l] != '1) begin
                            work_clf_nxt[l] = work_clf[l] + RES_WIDTH'(1);
                        end
`else
                        work_clf_nxt[l] = work_clf[l] + RES_WIDTH'(1);
`endif
                    end
                end
            end else begin
                work_rgs_nxt = rgs_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_clf  <= '0;
            work_rgs  <= '0;
            out_clf   <= '0;
            out_rgs   <= '0;
            tree_cnt  <= '0;
            state     <= ACCUM;
            leaf_rdy  <= 1'b1;
            accum_vld <= 1'b0;
        end else begin
            accum_vld <= emit;
            if (i_sample_rst) begin
                work_clf <= '0;
                work_rgs <= '0;
                tree_cnt <= '0;
                state    <= ACCUM;
                leaf_rdy <= 1'b1;
            end else if (emit) begin
                // In WAIT no leaf is accepted, so the _nxt values equal the held working state.
                out_clf  <= work_clf_nxt;
                out_rgs  <= work_rgs_nxt;
                work_clf <= '0;
                work_rgs <= '0;
                tree_cnt <= '0;
                state    <= ACCUM;
                leaf_rdy <= 1'b1;
            end else if (last_leaf) begin
                work_clf <= work_clf_nxt;
                work_rgs <= work_rgs_nxt;
                tree_cnt <= '0;
                state    <= WAIT;
                leaf_rdy <= 1'b0;
            end else if (accept) begin
                work_clf <= work_clf_nxt;
                work_rgs <= work_rgs_nxt;
                tree_cnt <= tree_cnt + N_TREES_WIDTH'(1);
            end
        end
    end

    vote_accum_gap_timer #(
        .W(GAP_W)
    ) u_gap_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (emit),
        .load_val (gap_load),
        .zero     (gap_zero)
    );

    assign o_leaf_rdy  = leaf_rdy;
    assign o_accum_vld = accum_vld;
    assign o_clf_accum = out_clf;
    assign o_rgs_accum = out_rgs;

endmodule

// File: tb/tb_tree_vote_accum.sv
// Scoreboard bench for tree_vote_accum: model pushes expected results, monitor pops on each pulse.
// Also checks pulse latency, spacing and output hold.
module tb_tree_vote_accum;

    localparam int NL = 10;
    localparam int LW = 4;
    localparam int RW = 16;
    localparam int TW = 17;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_sample_rst = 1'b0;
    logic [LW-1:0]     i_n_labels = '0;
    logic [TW-1:0]     i_n_trees = '0;
    logic              i_is_clf = 1'b0;
    logic              i_leaf_vld = 1'b0;
    logic              o_leaf_rdy;
    logic [LW-1:0]     i_leaf_label = '0;
    logic [RW-1:0]     i_leaf_value = '0;
    logic [NL*RW-1:0]  o_clf_accum;
    logic [RW-1:0]     o_rgs_accum;
    logic              o_accum_vld;

    always #5 clk = ~clk;

    tree_vote_accum #(
        .N_LABELS       (NL),
        .N_LABELS_WIDTH (LW),
        .RES_WIDTH      (RW),
        .N_TREES_WIDTH  (TW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_sample_rst (i_sample_rst),
        .i_n_labels   (i_n_labels),
        .i_n_trees    (i_n_trees),
        .i_is_clf     (i_is_clf),
        .i_leaf_vld   (i_leaf_vld),
        .o_leaf_rdy   (o_leaf_rdy),
        .i_leaf_label (i_leaf_label),
        .i_leaf_value (i_leaf_value),
        .o_clf_accum  (o_clf_accum),
        .o_rgs_accum  (o_rgs_accum),
        .o_accum_vld  (o_accum_vld)
    );

    typedef struct {
        logic [NL*RW-1:0] clf;
        logic [RW-1:0]    rgs;
        int               exp_cyc;
    } exp_t;

    exp_t             sb[$];
    exp_t             mon_e;
    logic [NL*RW-1:0] log_clf[$];
    logic [RW-1:0]    log_rgs[$];

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int last_pulse = -1;
    int prev_s = 0;
    int hold_left = 0;
    int stall_total = 0;
    bit want_exact = 1'b0;
    bit exact_spacing = 1'b0;
    logic [NL*RW-1:0] held_clf;
    logic [RW-1:0]    held_rgs;

    logic [RW-1:0] m_clf [NL];
    logic [RW-1:0] m_rgs;
    int            m_tree;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int spacing_now();
        if (!i_is_clf) return 3;
        return (int'(i_n_labels) + 2 > 5) ? int'(i_n_labels) + 2 : 5;
    endfunction

    function automatic void model_clear();
        for (int l = 0; l < NL; l++) m_clf[l] = '0;
        m_rgs  = '0;
        m_tree = 0;
    endfunction

    function automatic void model_accept(input logic [LW-1:0] lab, input logic [RW-1:0] val);
        int   s;
        int   n_eff;
        exp_t e;
        if (i_is_clf) begin
            if (lab < i_n_labels && int'(lab) < NL) begin
`ifdef VOTE_ACCUM_SATURATE_EN
                if (m_clf[lab] != 16'hFFFF) m_clf[lab] = m_clf[lab] + 16'd1;
`else
                m_clf[lab] = m_clf[lab] + 16'd1;
`endif
            end
        end else begin
            s = int'($signed(m_rgs)) + int'($signed(val));
`ifdef VOTE_ACCUM_SATURATE_EN
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
`endif
            m_rgs = 16'(s);
        end
        m_tree++;
        n_eff = (i_n_trees == '0) ? 1 : int'(i_n_trees);
        if (m_tree >= n_eff) begin
            for (int l = 0; l < NL; l++) e.clf[l*RW +: RW] = m_clf[l];
            e.rgs     = m_rgs;
            e.exp_cyc = want_exact ? cyc + 1 : -1;
            sb.push_back(e);
            model_clear();
        end
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_accum_vld) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", 160'(1), 160'(0));
                end else begin
                    mon_e = sb.pop_front();
                    check("clf_accum", 160'(o_clf_accum), 160'(mon_e.clf));
                    check("rgs_accum", 160'(o_rgs_accum), 160'(mon_e.rgs));
                    if (mon_e.exp_cyc >= 0) check("pulse_latency", 160'(cyc), 160'(mon_e.exp_cyc));
                end
                if (last_pulse >= 0) begin
                    if (exact_spacing) check("spacing_exact", 160'(cyc - last_pulse), 160'(prev_s));
                    else check("spacing_min", 160'(cyc - last_pulse >= prev_s), 160'(1));
                end
                log_clf.push_back(o_clf_accum);
                log_rgs.push_back(o_rgs_accum);
                last_pulse = cyc;
                prev_s     = spacing_now();
                hold_left  = prev_s - 1;
                held_clf   = o_clf_accum;
                held_rgs   = o_rgs_accum;
                pulse_cnt++;
            end else if (hold_left > 0) begin
                check("hold_clf", 160'(o_clf_accum), 160'(held_clf));
                check("hold_rgs", 160'(o_rgs_accum), 160'(held_rgs));
                hold_left--;
            end
        end
    end

    task automatic send(input logic [LW-1:0] lab, input logic [RW-1:0] val);
        int waitc = 0;
        i_leaf_vld   = 1'b1;
        i_leaf_label = lab;
        i_leaf_value = val;
        while (!o_leaf_rdy && waitc < 100) begin
            @(posedge clk);
            #1;
            waitc++;
        end
        stall_total += waitc;
        if (!o_leaf_rdy) check("rdy_timeout", 160'(0), 160'(1));
        model_accept(lab, val);
        @(posedge clk);
        #1;
        i_leaf_vld = 1'b0;
    endtask

    task automatic flush_with_leaf(input logic [LW-1:0] lab);
        i_sample_rst = 1'b1;
        i_leaf_vld   = 1'b1;
        i_leaf_label = lab;
        @(posedge clk);
        #1;
        i_sample_rst = 1'b0;
        i_leaf_vld   = 1'b0;
        model_clear();
    endtask

    task automatic cfg_set(input logic clf, input int nl, input int nt);
        repeat (20) @(posedge clk);
        #1;
        i_is_clf     = clf;
        i_n_labels   = LW'(nl);
        i_n_trees    = TW'(nt);
        i_sample_rst = 1'b1;
        @(posedge clk);
        #1;
        i_sample_rst = 1'b0;
        model_clear();
    endtask

    task automatic wait_pulses(input int target);
        int w = 0;
        while (pulse_cnt < target && w < 3000) begin
            @(negedge clk);
            w++;
        end
        check("pulse_wait", 160'(pulse_cnt >= target), 160'(1));
    endtask

    logic [NL*RW-1:0] want_clf;
    logic [RW-1:0]    wrap_exp;
    int               base;

    initial begin
        model_clear();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_clf", 160'(o_clf_accum), 160'(0));
        check("rst_rgs", 160'(o_rgs_accum), 160'(0));
        check("rst_vld", 160'(o_accum_vld), 160'(0));
        check("rst_rdy", 160'(o_leaf_rdy), 160'(1));

        // Classification, 3 labels, 4 trees
        cfg_set(1'b1, 3, 4);
        base = pulse_cnt;
        want_exact = 1'b1;
        send(4'd0, '0); send(4'd2, '0); send(4'd2, '0); send(4'd1, '0);
        want_exact = 1'b0;
        wait_pulses(base + 1);
        want_clf = '0;
        want_clf[15:0] = 16'd1; want_clf[31:16] = 16'd1; want_clf[47:32] = 16'd2;
        check("t1_counts", 160'(log_clf[base]), 160'(want_clf));

        // Regression, 2 trees then 1 tree
        cfg_set(1'b0, 3, 2);
        base = pulse_cnt;
        send(4'd0, 16'h0005); send(4'd0, 16'hFFFE);
        i_n_trees = TW'(1);
        i_sample_rst = 1'b1;
        @(posedge clk);
        #1;
        i_sample_rst = 1'b0;
        model_clear();
        send(4'd0, 16'h0010);
        wait_pulses(base + 2);
        check("t2_sum", 160'(log_rgs[base]), 160'(16'h0003));
        check("t2_sum2", 160'(log_rgs[base + 1]), 160'(16'h0010));

        // Classification, 10 labels, 1 tree, continuous leaves
        cfg_set(1'b1, 10, 1);
        base = pulse_cnt;
        stall_total = 0;
        send(4'd3, '0);
        wait_pulses(base + 1);
        exact_spacing = 1'b1;
        for (int i = 0; i < 5; i++) send(LW'(i * 2), '0);
        wait_pulses(base + 6);
        exact_spacing = 1'b0;
        check("t3_rdy_dropped", 160'(stall_total > 0), 160'(1));

        // Sample flush drops the concurrent leaf
        cfg_set(1'b1, 3, 3);
        base = pulse_cnt;
        send(4'd0, '0);
        flush_with_leaf(4'd1);
        send(4'd2, '0); send(4'd0, '0); send(4'd2, '0);
        wait_pulses(base + 1);
        want_clf = '0;
        want_clf[15:0] = 16'd1; want_clf[47:32] = 16'd2;
        check("t4_clean", 160'(log_clf[base]), 160'(want_clf));

        // n_trees = 0 behaves as 1; out-of-range label
        cfg_set(1'b1, 10, 0);
        base = pulse_cnt;
        send(4'd3, '0); send(4'd12, '0); send(4'd9, '0);
        wait_pulses(base + 3);
        check("t5_oor_label", 160'(log_clf[base + 1]), 160'(0));

        // Long run on label 0
        cfg_set(1'b1, 10, 70000);
        base = pulse_cnt;
        for (int i = 0; i < 70000; i++) send(4'd0, '0);
        wait_pulses(base + 1);
`ifdef VOTE_ACCUM_SATURATE_EN
        wrap_exp = 16'hFFFF;
`else
        wrap_exp = 16'd4464;
`endif
        check("t6_wrap", 160'(log_clf[base][15:0]), 160'(wrap_exp));

        repeat (20) @(posedge clk);
        check("sb_drained", 160'(sb.size()), 160'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
